// File: rtl/dcmac_0_pkt_stats_pkg.sv
// Shared types and constants for the time-sliced DCMAC RX packet statistics monitor.
package dcmac_0_pkt_stats_pkg;

    localparam int SEG_BYTES = 16;
    localparam int LEN_W     = 16;
    localparam int MTY_W     = 4;
    // Unsaturated running byte total of the open packet, so byte counts stay exact past 64 KiB.
    localparam int ACC_W     = 32;

    typedef struct packed {
        logic             ena;
        logic             sop;
        logic             eop;
        logic             err;
        logic [MTY_W-1:0] mty;
    } seg_ctl_t;

    typedef struct packed {
        logic             in_pkt;
        logic [LEN_W-1:0] len_acc;
        logic [ACC_W-1:0] byte_acc;
    } ch_ctx_t;

    // Per-beat statistics: event increments plus the beat's min/max packet length.
    typedef struct packed {
        logic [LEN_W-1:0] pkt;
        logic [ACC_W-1:0] bytes;
        logic [LEN_W-1:0] err_pkt;
        logic [LEN_W-1:0] runt;
        logic [LEN_W-1:0] oversize;
        logic [LEN_W-1:0] min_len;
        logic [LEN_W-1:0] max_len;
    } stats_t;

    function automatic logic [LEN_W-1:0] len_sat_add(input logic [LEN_W-1:0] a,
                                                     input logic [LEN_W-1:0] b);
        logic [LEN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LEN_W] ? '1 : s[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/dcmac_0_pkt_stats_seg_walk.sv
// Combinational scan of one beat's segments: owning channel context in, per-beat stats and new context out.
module dcmac_0_pkt_stats_seg_walk
    import dcmac_0_pkt_stats_pkg::*;
#(
    parameter int NUM_SEG = 12,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 9600
) (
    input  seg_ctl_t [NUM_SEG-1:0] seg,
    input  ch_ctx_t                ctx_in,
    output ch_ctx_t                ctx_out,
    output stats_t                 inc,
    output logic                   frame_err
);

    logic [LEN_W-1:0] seg_bytes;

    always_comb begin
        ctx_out     = ctx_in;
        inc         = '0;
        inc.min_len = '1;
        inc.max_len = '0;
        frame_err   = 1'b0;
        seg_bytes   = '0;
        for (int s = 0; s < NUM_SEG; s++) begin
            if (seg[s].ena) begin
                if (seg[s].sop) begin
                    // A sop inside an open packet abandons the partial one.
                    if (ctx_out.in_pkt) frame_err = 1'b1;
                    ctx_out.in_pkt   = 1'b1;
                    ctx_out.len_acc  = '0;
                    ctx_out.byte_acc = '0;
                end else if (seg[s].eop && !ctx_out.in_pkt) begin
                    frame_err = 1'b1;
                end
                seg_bytes = seg[s].eop ? LEN_W'(SEG_BYTES) - LEN_W'(seg[s].mty)
                                       : LEN_W'(SEG_BYTES);
                ctx_out.len_acc  = len_sat_add(ctx_out.len_acc, seg_bytes);
                ctx_out.byte_acc = ctx_out.byte_acc + ACC_W'(seg_bytes);
                if (seg[s].eop) begin
                    inc.pkt   = inc.pkt + LEN_W'(1);
                    inc.bytes = inc.bytes + ctx_out.byte_acc;
                    if (seg[s].err)                           inc.err_pkt  = inc.err_pkt + LEN_W'(1);
                    if (ctx_out.len_acc < LEN_W'(MIN_LEN))    inc.runt     = inc.runt + LEN_W'(1);
                    if (ctx_out.len_acc > LEN_W'(MAX_LEN))    inc.oversize = inc.oversize + LEN_W'(1);
                    if (ctx_out.len_acc < inc.min_len)        inc.min_len  = ctx_out.len_acc;
                    if (ctx_out.len_acc > inc.max_len)        inc.max_len  = ctx_out.len_acc;
                    ctx_out.in_pkt   = 1'b0;
                    ctx_out.len_acc  = '0;
                    ctx_out.byte_acc = '0;
                end
            end
        end
    end

endmodule

// File: rtl/dcmac_0_axis_pkt_stats_ts.sv
// Time-sliced per-channel RX statistics for the DCMAC segmented AXIS bus, with snapshot/clear-on-read.
// The bus is valid-only: a segment is consumed whenever its ena bit is set; there is no ready/backpressure.
module dcmac_0_axis_pkt_stats_ts
    import dcmac_0_pkt_stats_pkg::*;
#(
    parameter int NUM_CH   = 6,
    parameter int NUM_SEG  = 12,
    parameter int ID_W     = 3,
    parameter int CNT_W    = 64,
    parameter int MIN_LEN  = 64,
    parameter int MAX_LEN  = 9600,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         port_rst,
    input  logic [ID_W-1:0]           i_id,
    input  logic [NUM_SEG-1:0]        i_ena,
    input  logic [NUM_SEG-1:0]        i_sop,
    input  logic [NUM_SEG-1:0]        i_eop,
    input  logic [NUM_SEG-1:0]        i_err,
    input  logic [NUM_SEG*MTY_W-1:0]  i_mty,
    input  logic [NUM_CH-1:0]         i_snapshot,
    input  logic [NUM_CH-1:0]         i_clear_counters,
    output logic [NUM_CH*CNT_W-1:0]   o_pkt_cnt,
    output logic [NUM_CH*CNT_W-1:0]   o_byte_cnt,
    output logic [NUM_CH*CNT_W-1:0]   o_err_pkt_cnt,
    output logic [NUM_CH*CNT_W-1:0]   o_runt_cnt,
    output logic [NUM_CH*CNT_W-1:0]   o_oversize_cnt,
    output logic [NUM_CH*LEN_W-1:0]   o_min_len,
    output logic [NUM_CH*LEN_W-1:0]   o_max_len,
    output logic [NUM_CH-1:0]         o_frame_err
);

    function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [CNT_W+ACC_W-1:0] s;
        s = {{ACC_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        if (SATURATE != 0 && s[CNT_W+ACC_W-1:CNT_W] != '0) return '1;
        return s[CNT_W-1:0];
    endfunction

    // Stage 1: register the beat; a beat for a channel under port_rst is dropped here.
    logic                   beat_drop;
    logic [ID_W-1:0]        id_q;
    seg_ctl_t [NUM_SEG-1:0] seg_q;

    always_comb begin
        beat_drop = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if (i_id == ID_W'(c) && port_rst[c]) beat_drop = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q  <= '0;
            seg_q <= '0;
        end else begin
            id_q <= i_id;
            for (int s = 0; s < NUM_SEG; s++) begin
                seg_q[s].ena <= i_ena[s] & ~beat_drop;
                seg_q[s].sop <= i_sop[s];
                seg_q[s].eop <= i_eop[s];
                seg_q[s].err <= i_err[s];
                seg_q[s].mty <= i_mty[s*MTY_W +: MTY_W];
            end
        end
    end

    // Stage 2: segment walk against the owning channel's context.
    ch_ctx_t             ctx_q [NUM_CH];
    ch_ctx_t             ctx_cur;
    ch_ctx_t             ctx_nxt;
    stats_t              beat_inc;
    logic                beat_ferr;
    logic                any_ena;
    logic [NUM_CH-1:0]   own;

    always_comb begin
        ctx_cur = '0;
        any_ena = 1'b0;
        own     = '0;
        for (int s = 0; s < NUM_SEG; s++) any_ena = any_ena | seg_q[s].ena;
        for (int c = 0; c < NUM_CH; c++) begin
            if (id_q == ID_W'(c)) begin
                ctx_cur = ctx_q[c];
                own[c]  = any_ena;
            end
        end
    end

    dcmac_0_pkt_stats_seg_walk #(
        .NUM_SEG (NUM_SEG),
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN)
    ) u_seg_walk (
        .seg       (seg_q),
        .ctx_in    (ctx_cur),
        .ctx_out   (ctx_nxt),
        .inc       (beat_inc),
        .frame_err (beat_ferr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) ctx_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (port_rst[c])  ctx_q[c] <= '0;
                else if (own[c])  ctx_q[c] <= ctx_nxt;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        stats_t           ci;
        logic             fe;
        logic             clr;
        logic [CNT_W-1:0] pkt_q, byte_q, errp_q, runt_q, over_q;
        logic [CNT_W-1:0] s_pkt_q, s_byte_q, s_errp_q, s_runt_q, s_over_q;
        logic [LEN_W-1:0] min_q, max_q, s_min_q, s_max_q;
        logic             ferr_q;

        always_comb begin
            ci         = '0;
            ci.min_len = '1;
            fe         = 1'b0;
            clr        = i_clear_counters[c];
            if (own[c]) begin
                ci = beat_inc;
                fe = beat_ferr;
            end
        end

        // Clear keeps this edge's increment, so clear-on-read loses no events.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pkt_q    <= '0;  byte_q   <= '0;  errp_q   <= '0;  runt_q   <= '0;  over_q   <= '0;
                s_pkt_q  <= '0;  s_byte_q <= '0;  s_errp_q <= '0;  s_runt_q <= '0;  s_over_q <= '0;
                min_q    <= '1;  max_q    <= '0;  s_min_q  <= '1;  s_max_q  <= '0;
                ferr_q   <= 1'b0;
            end else begin
                if (i_snapshot[c]) begin
                    s_pkt_q  <= pkt_q;
                    s_byte_q <= byte_q;
                    s_errp_q <= errp_q;
                    s_runt_q <= runt_q;
                    s_over_q <= over_q;
                    s_min_q  <= min_q;
                    s_max_q  <= max_q;
                end
                pkt_q  <= cnt_add(clr ? '0 : pkt_q,  ACC_W'(ci.pkt));
                byte_q <= cnt_add(clr ? '0 : byte_q, ci.bytes);
                errp_q <= cnt_add(clr ? '0 : errp_q, ACC_W'(ci.err_pkt));
                runt_q <= cnt_add(clr ? '0 : runt_q, ACC_W'(ci.runt));
                over_q <= cnt_add(clr ? '0 : over_q, ACC_W'(ci.oversize));
                min_q  <= (clr || ci.min_len < min_q) ? ci.min_len : min_q;
                max_q  <= (clr || ci.max_len > max_q) ? ci.max_len : max_q;
                ferr_q <= fe | (ferr_q & ~clr);
            end
        end

        assign o_pkt_cnt[c*CNT_W +: CNT_W]      = s_pkt_q;
        assign o_byte_cnt[c*CNT_W +: CNT_W]     = s_byte_q;
        assign o_err_pkt_cnt[c*CNT_W +: CNT_W]  = s_errp_q;
        assign o_runt_cnt[c*CNT_W +: CNT_W]     = s_runt_q;
        assign o_oversize_cnt[c*CNT_W +: CNT_W] = s_over_q;
        assign o_min_len[c*LEN_W +: LEN_W]      = s_min_q;
        assign o_max_len[c*LEN_W +: LEN_W]      = s_max_q;
        assign o_frame_err[c]                   = ferr_q;
    end

endmodule
